// File: rtl/pe_arb_pkg.sv
// Shared constants for the PE FIFO write-side arbiter: FSM encoding and default sizing.
package pe_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_BURST_LEN = 4;
  localparam int BEAT_CNT_W    = 4;

endpackage

// File: rtl/pe_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set strictly after rr_last,
// wrapping, so rr_last itself has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  int cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    cand       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_last) + off) % NUM_REQ;
      if (!any_valid && req[cand]) begin
        any_valid      = 1'b1;
        winner[cand]   = 1'b1;
        winner_idx     = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pe_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bursts of up to BURST_LEN beats with zero-cycle handover.
module pe_fifo_wr_arbiter
  import pe_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          full_flag,
  input  logic                          wr_en,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr_request,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                  state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_last_q, rr_last_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;

  logic [IDX_W-1:0]      pick_base;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  owner_req;
  logic                  owner_last;
  logic                  beat;
  logic                  release_now;

  // While granted, re-arbitration starts after the current owner, which is exactly
  // the rr_last value the release edge commits; idle arbitration uses the stored one.
  assign pick_base = (state_q == ST_GRANT) ? owner_q : rr_last_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .rr_last    (pick_base),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_valid  (pick_valid)
  );

  assign owner_req   = req[owner_q];
  assign owner_last  = req_last[owner_q];
  assign beat        = (state_q == ST_GRANT) && wr_en && !full_flag;
  assign release_now = (state_q == ST_GRANT) &&
                       ((beat && ((beat_cnt_q == BEAT_CNT_W'(BURST_LEN - 1)) || owner_last)) ||
                        !owner_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_last_q  <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_GRANT;
          gnt_d      = pick_onehot;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          rr_last_d  = owner_q;
          beat_cnt_d = '0;
          if (pick_valid) begin
            gnt_d   = pick_onehot;
            owner_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_GRANT);
    gnt        = gnt_q;
    wr_request = busy && owner_req;
    wr_data    = busy ? req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    ack        = gnt_q & {NUM_REQ{wr_en}};
  end

endmodule

// File: tb/tb_pe_fifo_wr_arbiter.sv
// Randomized bench for pe_fifo_wr_arbiter against a transaction-level model of
// requesters, the write controller and the round-robin burst rules.
module tb_pe_fifo_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            full_flag;
  logic            wr_en;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            wr_request;
  logic [DW-1:0]   wr_data;
  logic            busy;

  pe_fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .full_flag  (full_flag),
    .wr_en      (wr_en),
    .gnt        (gnt),
    .ack        (ack),
    .wr_request (wr_request),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // Write controller: accepts whenever asked and not full.
  assign wr_en = wr_request & ~full_flag;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: each source has a packet of pkt_rem beats, a running sequence number
  // that tags its data, and may idle between beats (only right after an ack).
  int pkt_rem [N];
  int seq     [N];
  bit paused  [N];
  int p_full, p_pause, max_len;

  // Reference arbiter state, in terms of "who owns the port and how many beats so far".
  bit m_busy;
  int m_owner;
  int m_rr_last;
  int m_beats;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]                = (pkt_rem[i] > 0) && !paused[i];
      req_last[i]           = (pkt_rem[i] == 1);
      req_data[i*DW +: DW]  = DW'((i << 12) | (seq[i] & 'hfff));
    end
    full_flag = ($urandom_range(99) < p_full);
  endtask

  task automatic advance(input logic [N-1:0] acked);
    for (int i = 0; i < N; i++) begin
      if (acked[i]) begin
        pkt_rem[i]--;
        seq[i]++;
        paused[i] = ($urandom_range(99) < p_pause);
      end else if (paused[i] && $urandom_range(1) == 0) begin
        paused[i] = 1'b0;
      end
      if (pkt_rem[i] == 0 && $urandom_range(3) == 0)
        pkt_rem[i] = $urandom_range(max_len, 1);
    end
  endtask

  function automatic int next_after(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_owner   = 0;
    m_rr_last = N - 1;
    m_beats   = 0;
  endtask

  task automatic run_cycle();
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_ack;
    logic          e_req;
    logic [DW-1:0] e_data;
    int            c;
    @(negedge clk);
    e_gnt  = m_busy ? N'(1 << m_owner) : '0;
    e_req  = m_busy && req[m_owner];
    e_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
    e_ack  = (e_req && !full_flag) ? e_gnt : '0;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("busy", 32'(busy), 32'(m_busy));
    check("wr_request", 32'(wr_request), 32'(e_req));
    check("wr_data", 32'(wr_data), 32'(e_data));
    check("ack", 32'(ack), 32'(e_ack));
    if (e_ack != '0)
      $display("beat: req %0d data %h burst_beat %0d", m_owner, e_data, m_beats + 1);
    if (!m_busy) begin
      c = next_after(req, m_rr_last);
      if (c >= 0) begin
        m_busy  = 1'b1;
        m_owner = c;
        m_beats = 0;
      end
    end else begin
      if (e_ack != '0) m_beats++;
      if (!req[m_owner] || (e_ack != '0 && (m_beats == BL || req_last[m_owner]))) begin
        m_rr_last = m_owner;
        c = next_after(req, m_owner);
        if (c >= 0) begin
          m_owner = c;
          m_beats = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    advance(e_ack);
    drive_inputs();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_request", 32'(wr_request), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      pkt_rem[i] = 0;
      seq[i]     = 0;
      paused[i]  = 1'b0;
    end
    p_full = 0; p_pause = 0; max_len = 20;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("init_gnt", 32'(gnt), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_wr_request", 32'(wr_request), 32'd0);
    #2 reset = 1'b0;
    model_reset();

    // All sources busy with long packets: strict 0,1,2,0 bursts of BL, then reset mid-burst.
    for (int i = 0; i < N; i++) pkt_rem[i] = 20;
    drive_inputs();
    repeat (30) run_cycle();
    pulse_reset();
    repeat (20) run_cycle();

    // Random back-pressure, short packets, idle gaps.
    p_full = 30; p_pause = 30; max_len = 8;
    repeat (300) run_cycle();
    pulse_reset();
    repeat (300) run_cycle();

    // Frequent req drops right after acks and very short packets.
    p_full = 0; p_pause = 50; max_len = 3;
    repeat (200) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_fifo_wr_arbiter.md
# pe_fifo_wr_arbiter

Round-robin write-side arbiter that shares one scratchpad/FIFO write port among NUM_REQ requesters (ifmap, filter, psum sources). It grants one requester for a burst of up to BURST_LEN beats and drives the FIFO write controller's `wr_request`/`wr_data`. It consumes that controller's `wr_en` and `full_flag` as the accept/back-pressure signals. It sits between the PE input buses and the write controller.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 16, write-data width, equal to the write controller's W_DATA_WIDTH
- BURST_LEN, 4, maximum beats per grant (1..15)
- clk  input  1  clock; all arbiter state on posedge
- reset  input  1  reset, asynchronous, active-high
- req  input  NUM_REQ  per-requester write request, level, held until acked
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  NUM_REQ  current beat is last of requester's packet
- full_flag  input  1  from write controller; FIFO full
- wr_en  input  1  from write controller; beat accepted this cycle
- gnt  output  NUM_REQ  one-hot registered grant, 0 when idle
- ack  output  NUM_REQ  one-hot, requester's current beat accepted (= gnt & {wr_en})
- wr_request  output  1  to write controller
- wr_data  output  DATA_WIDTH  to write controller; muxed from granted requester
- busy  output  1  FSM in GRANT

## Operation
- FSM states IDLE, GRANT; registers: state, owner index, rr_last index, beat_cnt (4 bits).
- IDLE: if any req, pick first requester set at or after (rr_last+1) mod NUM_REQ; load gnt/owner, beat_cnt=0, go GRANT. Else stay.
- GRANT: wr_request = req[owner]; wr_data = req_data[owner]; ack[owner] = wr_en. beat = wr_en at posedge.
- Release condition at posedge: (beat and (beat_cnt==BURST_LEN-1 or req_last[owner])) or req[owner]==0.
- On release: rr_last=owner; re-arbitrate in the same edge with rr_last=owner, including owner only if still requesting and no other requester pending; grant new winner (stay GRANT) or go IDLE with gnt=0. No bubble on back-to-back grants.
- No release: beat_cnt += beat.
- full_flag high: wr_en low, no beat counted, grant held indefinitely; no timeout.
- Requester changes req_data only after its ack; the arbiter does not buffer data.
- Outputs when IDLE: wr_request=0, wr_data=0, ack=0.
- Reset (any time, incl. mid-burst): state=IDLE, gnt=0, ack=0, wr_request=0, wr_data=0, busy=0, beat_cnt=0, rr_last=NUM_REQ-1 (requester 0 has first priority). A partial burst is abandoned; the write controller's own reset covers pointers.

## Timing
- req rising before posedge k: gnt/busy high after posedge k; first beat can be accepted at posedge k+1 (latency 1 cycle from grant).
- wr_request/wr_data/ack are combinational from registered gnt and inputs; wr_en returns combinationally from write controller (wr_request & ~full_flag) and is sampled at posedge. The write controller advances its pointer on the preceding negedge; no extra stage here.
- Throughput: 1 beat/cycle while not full; grant handover costs 0 cycles.
- Simultaneous req from all: service order 0,1,2,0,... by burst.
- Last beat and req drop on same edge: treated as one release, no double rr advance.

## Structure
- Shared package pe_arb_pkg: FSM state localparams (ST_IDLE, ST_GRANT), default NUM_REQ, BURST_LEN, beat-counter width constant.
- Sub-module rr_pick: combinational, inputs req vector and rr_last, outputs one-hot winner, index, and any_valid. Used for both IDLE grant and release-time re-grant.
- Top holds FSM, beat counter, data mux.

## Test plan
- Single requester 1, 6 beats, no req_last, not full -> gnt=010 after 1 cycle, acks 4 beats, release, re-grant to 1 with no idle cycle, 2 more beats.
- All three requesting continuously, BURST_LEN=4 -> bursts of 4 in order 0,1,2,0; wr_request never drops between bursts.
- req_last on beat 2 of requester 0 while 2 pending -> grant moves to 2 after 2 beats; beat_cnt restarts at 0.
- full_flag high 5 cycles mid-burst after beat 1 -> ack=0, gnt held, beat_cnt stays 1; on full low, beats 2-4 complete and release.
- Owner drops req after 1 beat -> immediate release, rr_last=owner, next pending requester granted.
- reset pulse mid-burst (beat 2 of requester 1) -> all outputs 0 asynchronously; after release with all requesting, requester 0 granted first.
